// File: rtl/sub_4bit_serial.sv
// Slice-serial unsigned subtractor: a - b, SLICE bits per clock, LSB first.
// Operands in and result out over valid/ready; borrow chained across slices.
module sub_4bit_serial #(
  parameter int WIDTH = 4,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             underflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] ak;
  logic [SLICE-1:0] bk;
  logic [SLICE:0]   s;
  logic             borrow_n;
  logic [WIDTH-1:0] res_n;

  // Constant-indexed slice select keeps the mux explicit.
  always_comb begin
    ak    = '0;
    bk    = '0;
    res_n = res;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        ak = a_r[k*SLICE +: SLICE];
        bk = b_r[k*SLICE +: SLICE];
      end
    end
    s = {1'b0, ak} - {1'b0, bk}
      - {{SLICE{1'b0}}, borrow};
    borrow_n = s[SLICE];
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        res_n[k*SLICE +: SLICE] = s[SLICE-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      res       <= '0;
      borrow    <= 1'b0;
      idx       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow   <= 1'b0;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
          end
        end
        RUN: begin
          res    <= res_n;
          borrow <= borrow_n;
          idx    <= idx + IW'(1);
          if (idx == IW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            diff      <= {borrow_n, res_n};
            underflow <= borrow_n;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_4bit_serial.sv
// Directed + random bench for sub_4bit_serial.
// Scoreboard queue filled on accept, drained on consume.
module tb_sub_4bit_serial;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] diff;
  logic       underflow;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic last_acc;
  logic last_con;
  logic [4:0] sb[$];

  sub_4bit_serial #(.WIDTH(4), .SLICE(2)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff(diff),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: timeout got none want event", tag);
  endtask

  // One clock: score handshakes seen before the edge, sample #1 after.
  task automatic tick();
    logic [4:0] e;
    last_acc = in_valid && in_ready && !rst;
    last_con = out_valid && out_ready && !rst;
    if (last_con) begin
      if (sb.size() == 0) begin
        tmo("sb_empty");
      end else begin
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e));
        chk("underflow", 32'(underflow), 32'(e[4]));
      end
    end
    if (last_acc) sb.push_back({1'b0, a} - {1'b0, b});
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y);
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    out_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 10);
    if (!last_acc) tmo("accept");
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) tmo("consume");
  endtask

  initial begin
    int n;
    int nacc;
    int prev;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_underflow", 32'(underflow), 0);

    // Basic op with borrow chain and latency
    a = 4'd4;
    b = 4'd1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("basic_acc", 32'(last_acc), 1);
    in_valid = 1'b0;
    tick();
    chk("basic_ov_e1", 32'(out_valid), 0);
    tick();
    chk("basic_ov_e2", 32'(out_valid), 1);
    chk("basic_ir", 32'(in_ready), 0);
    chk("basic_diff", 32'(diff), 32'h03);
    tick();
    chk("basic_ir_after", 32'(in_ready), 1);
    chk("basic_ov_after", 32'(out_valid), 0);

    run_op(4'd3, 4'd9);
    chk("neg1_diff", 32'(diff), 32'h1a);
    chk("neg1_uf", 32'(underflow), 1);
    run_op(4'd0, 4'd15);
    chk("neg2_diff", 32'(diff), 32'h11);
    run_op(4'd15, 4'd0);
    chk("max_diff", 32'(diff), 32'h0f);
    chk("max_uf", 32'(underflow), 0);
    run_op(4'd7, 4'd7);
    chk("zero_diff", 32'(diff), 32'h00);

    // Backpressure with a second request pending
    a = 4'd9;
    b = 4'd3;
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    chk("bp_acc", 32'(last_acc), 1);
    a = 4'd5;
    b = 4'd2;
    tick();
    tick();
    chk("bp_ov", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_diff", 32'(diff), 32'h06);
      chk("bp_hold_ov", 32'(out_valid), 1);
      chk("bp_hold_ir", 32'(in_ready), 0);
      chk("bp_no_acc", 32'(last_acc), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_con", 32'(last_con), 1);
    chk("bp_no_bypass", 32'(last_acc), 0);
    chk("bp_ir_back", 32'(in_ready), 1);
    tick();
    chk("bp_acc2", 32'(last_acc), 1);
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) tmo("bp_drain");
    chk("bp2_diff", 32'(diff), 32'h03);

    // Reset one cycle into RUN
    a = 4'd3;
    b = 4'd9;
    in_valid = 1'b1;
    tick();
    chk("mr_acc", 32'(last_acc), 1);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    chk("mr_ir", 32'(in_ready), 1);
    chk("mr_ov", 32'(out_valid), 0);
    chk("mr_diff", 32'(diff), 0);
    chk("mr_uf", 32'(underflow), 0);
    run_op(4'd9, 4'd3);
    chk("mr_next_diff", 32'(diff), 32'h06);

    // Back-to-back random throughput
    in_valid = 1'b1;
    out_ready = 1'b1;
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    nacc = 0;
    prev = 0;
    n = 0;
    while (nacc < 16 && n < 200) begin
      tick();
      n++;
      if (last_acc) begin
        if (nacc > 0) chk("b2b_gap", 32'(cyc - prev), 4);
        prev = cyc;
        nacc++;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
      end
    end
    if (nacc < 16) tmo("b2b_accepts");
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) tmo("b2b_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
